// File: rtl/pwm_counter.sv
// Enable-gated pulse-width up-counter with sticky overflow and optional falling-edge capture.
// Define PWM_COUNTER_CAPTURE_EN to build the capture register; otherwise the capture outputs are tied to 0.
module pwm_counter #(
  parameter int unsigned WIDTH        = 26,
  parameter bit          SATURATE     = 1'b0,
  parameter bit          AUTO_RESTART = 1'b0
) (
  input  logic             CLOCK_50,
  input  logic             Clear,
  input  logic             SysClock_Enabler,
  output logic [WIDTH-1:0] CountValue,
  output logic             Overflow,
  output logic [WIDTH-1:0] CaptureValue,
  output logic             CaptureValid
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic en_d;
  logic post_clr;
  logic rise;

  // The first edge after Clear only reloads en_d, so a level that was already
  // high when Clear dropped never counts as a fresh pulse start.
  assign rise = SysClock_Enabler & ~en_d & ~post_clr;

  always_ff @(posedge CLOCK_50 or posedge Clear) begin
    if (Clear) begin
      en_d       <= 1'b0;
      post_clr   <= 1'b1;
      CountValue <= '0;
      Overflow   <= 1'b0;
    end else begin
      en_d     <= SysClock_Enabler;
      post_clr <= 1'b0;
      if (AUTO_RESTART && rise) begin
        CountValue <= CNT_ONE;
        Overflow   <= 1'b0;
      end else if (SysClock_Enabler) begin
        if (CountValue != CNT_MAX) begin
          CountValue <= CountValue + CNT_ONE;
        end else begin
          Overflow <= 1'b1;
          if (!SATURATE) CountValue <= '0;
        end
      end
    end
  end

`ifdef PWM_COUNTER_CAPTURE_EN
  logic armed;
  logic fall;

  assign fall = ~SysClock_Enabler & en_d;

  // armed marks a pulse whose start was observed; pulses cut by Clear never capture.
  always_ff @(posedge CLOCK_50 or posedge Clear) begin
    if (Clear) begin
      armed        <= 1'b0;
      CaptureValue <= '0;
      CaptureValid <= 1'b0;
    end else begin
      CaptureValid <= 1'b0;
      if (rise) begin
        armed <= 1'b1;
      end else if (fall) begin
        armed <= 1'b0;
        if (armed) begin
          CaptureValue <= CountValue;
          CaptureValid <= 1'b1;
        end
      end
    end
  end
`else
  assign CaptureValue = '0;
  assign CaptureValid = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_counter.sv
// Directed bench for pwm_counter: four instances cover the default, wrap, saturate
// and auto-restart configurations; capture expectations follow PWM_COUNTER_CAPTURE_EN.
module tb_pwm_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

`ifdef PWM_COUNTER_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic        clr_b, en_b, ovf_b, cv_b;
  logic [25:0] cnt_b, cap_b;
  logic        clr_w, en_w, ovf_w, cv_w;
  logic [3:0]  cnt_w, cap_w;
  logic        clr_s, en_s, ovf_s, cv_s;
  logic [3:0]  cnt_s, cap_s;
  logic        clr_a, en_a, ovf_a, cv_a;
  logic [25:0] cnt_a, cap_a;

  pwm_counter #(.WIDTH(26), .SATURATE(1'b0), .AUTO_RESTART(1'b0)) u_base (
    .CLOCK_50(clk), .Clear(clr_b), .SysClock_Enabler(en_b), .CountValue(cnt_b),
    .Overflow(ovf_b), .CaptureValue(cap_b), .CaptureValid(cv_b));

  pwm_counter #(.WIDTH(4), .SATURATE(1'b0), .AUTO_RESTART(1'b0)) u_wrap (
    .CLOCK_50(clk), .Clear(clr_w), .SysClock_Enabler(en_w), .CountValue(cnt_w),
    .Overflow(ovf_w), .CaptureValue(cap_w), .CaptureValid(cv_w));

  pwm_counter #(.WIDTH(4), .SATURATE(1'b1), .AUTO_RESTART(1'b0)) u_sat (
    .CLOCK_50(clk), .Clear(clr_s), .SysClock_Enabler(en_s), .CountValue(cnt_s),
    .Overflow(ovf_s), .CaptureValue(cap_s), .CaptureValid(cv_s));

  pwm_counter #(.WIDTH(26), .SATURATE(1'b0), .AUTO_RESTART(1'b1)) u_ar (
    .CLOCK_50(clk), .Clear(clr_a), .SysClock_Enabler(en_a), .CountValue(cnt_a),
    .Overflow(ovf_a), .CaptureValue(cap_a), .CaptureValid(cv_a));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    en_b = 1'b1;
    tick(37);
    en_b = 1'b0;
    total++;
    if (cnt_b !== 26'd37) begin
      bad++; $display("FAIL reset_precount: got %0d want 37", cnt_b);
    end
    #1 clr_b = 1'b1;
    #1;
    total++;
    if (cnt_b !== 26'd0 || ovf_b !== 1'b0 || cap_b !== 26'd0 || cv_b !== 1'b0) begin
      bad++; $display("FAIL reset_async: got cnt=%0d ovf=%0b cap=%0d cv=%0b want all 0",
                      cnt_b, ovf_b, cap_b, cv_b);
    end
    #1 clr_b = 1'b0;
    tick(4);
    total++;
    if (cnt_b !== 26'd0 || ovf_b !== 1'b0) begin
      bad++; $display("FAIL reset_release: got cnt=%0d ovf=%0b want 0 0", cnt_b, ovf_b);
    end
  endtask

  task automatic test_accumulate;
    en_b = 1'b1;
    tick(50);
    en_b = 1'b0;
    total++;
    if (cnt_b !== 26'd50) begin
      bad++; $display("FAIL accum_50: got %0d want 50", cnt_b);
    end
    tick(7);
    total++;
    if (cnt_b !== 26'd50 || ovf_b !== 1'b0) begin
      bad++; $display("FAIL accum_hold: got cnt=%0d ovf=%0b want 50 0", cnt_b, ovf_b);
    end
    total++;
    if (cv_b !== 1'b0 && !CAP) begin
      bad++; $display("FAIL accum_nocap: got cv=%0b want 0", cv_b);
    end
    en_b = 1'b1;
    tick(10);
    en_b = 1'b0;
    tick(2);
    total++;
    if (cnt_b !== 26'd60) begin
      bad++; $display("FAIL accum_60: got %0d want 60", cnt_b);
    end
  endtask

  task automatic test_wrap;
    logic [3:0] exp_cnt;
    logic       exp_ovf;
    en_w = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick(1);
      exp_cnt = 4'(i % 16);
      exp_ovf = (i >= 16);
      total++;
      if (cnt_w !== exp_cnt || ovf_w !== exp_ovf) begin
        bad++; $display("FAIL wrap_edge%0d: got cnt=%0d ovf=%0b want %0d %0b",
                        i, cnt_w, ovf_w, exp_cnt, exp_ovf);
      end
    end
    en_w = 1'b0;
    tick(3);
    total++;
    if (cnt_w !== 4'd1 || ovf_w !== 1'b1) begin
      bad++; $display("FAIL wrap_sticky: got cnt=%0d ovf=%0b want 1 1", cnt_w, ovf_w);
    end
  endtask

  task automatic test_saturate;
    en_s = 1'b1;
    tick(15);
    total++;
    if (cnt_s !== 4'd15 || ovf_s !== 1'b0) begin
      bad++; $display("FAIL sat_at_max: got cnt=%0d ovf=%0b want 15 0", cnt_s, ovf_s);
    end
    tick(5);
    en_s = 1'b0;
    total++;
    if (cnt_s !== 4'd15 || ovf_s !== 1'b1) begin
      bad++; $display("FAIL sat_hold: got cnt=%0d ovf=%0b want 15 1", cnt_s, ovf_s);
    end
  endtask

  task automatic check_capture(input string nm, input logic [25:0] want);
    total++;
    if (CAP) begin
      if (cap_a !== want || cv_a !== 1'b1) begin
        bad++; $display("FAIL %s: got cap=%0d cv=%0b want %0d 1", nm, cap_a, cv_a, want);
      end
    end else if (cap_a !== 26'd0 || cv_a !== 1'b0) begin
      bad++; $display("FAIL %s: got cap=%0d cv=%0b want 0 0 (no capture build)", nm, cap_a, cv_a);
    end
    tick(1);
    total++;
    if (cv_a !== 1'b0) begin
      bad++; $display("FAIL %s_pulse: got cv=%0b want 0 one cycle later", nm, cv_a);
    end
  endtask

  task automatic test_back_to_back;
    en_a = 1'b1;
    tick(500);
    en_a = 1'b0;
    total++;
    if (cnt_a !== 26'd500) begin
      bad++; $display("FAIL ar_cnt500: got %0d want 500", cnt_a);
    end
    tick(1);
    check_capture("cap500", 26'd500);
    tick(3);
    en_a = 1'b1;
    tick(1);
    total++;
    if (cnt_a !== 26'd1) begin
      bad++; $display("FAIL ar_restart: got %0d want 1", cnt_a);
    end
    tick(949);
    en_a = 1'b0;
    tick(1);
    check_capture("cap950", 26'd950);
    total++;
    if (cnt_a !== 26'd950 || ovf_a !== 1'b0) begin
      bad++; $display("FAIL ar_hold950: got cnt=%0d ovf=%0b want 950 0", cnt_a, ovf_a);
    end
  endtask

  task automatic test_clear_abort;
    logic seen;
    en_a = 1'b1;
    tick(10);
    #1 clr_a = 1'b1;
    #1;
    total++;
    if (cnt_a !== 26'd0 || cv_a !== 1'b0 || cap_a !== 26'd0) begin
      bad++; $display("FAIL abort_clear: got cnt=%0d cv=%0b cap=%0d want 0 0 0", cnt_a, cv_a, cap_a);
    end
    #1 clr_a = 1'b0;
    tick(5);
    total++;
    if (cnt_a !== 26'd5) begin
      bad++; $display("FAIL abort_recount: got %0d want 5", cnt_a);
    end
    en_a = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (cv_a !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL abort_nocap: got a CaptureValid pulse want none (cap=%0d)", cap_a);
    end
    en_a = 1'b1;
    tick(20);
    en_a = 1'b0;
    tick(1);
    check_capture("cap20", 26'd20);
  endtask

  initial begin
    clr_b = 1'b1; clr_w = 1'b1; clr_s = 1'b1; clr_a = 1'b1;
    en_b  = 1'b0; en_w  = 1'b0; en_s  = 1'b0; en_a  = 1'b0;
    #12;
    clr_b = 1'b0; clr_w = 1'b0; clr_s = 1'b0; clr_a = 1'b0;
    tick(2);
    test_reset();
    test_accumulate();
    test_wrap();
    test_saturate();
    test_back_to_back();
    test_clear_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
